writeback_unit: RTL and testbench
=================================

# writeback_unit

Parametrised write-back stage for the pipelined RISC-V core. It selects the architectural result from one of four sources and sign- or zero-extends sub-word loads. The result, destination register and write enable are registered with stall and flush control, and drive the register-file write port in decode. An optional retired-instruction counter can be compiled in.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- REG_AW, 5, register address width.
- OFF_W, $clog2(XLEN/8), width of the load byte offset.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_w  in  1  the W-stage instruction is real, not a bubble.
- stall_w  in  1  hold the output register.
- flush_w  in  1  replace the next register contents with a bubble.
- reg_write_w  in  1  the instruction writes the register file.
- result_sel_w  in  2  result source: 0 ALU, 1 LOAD, 2 PC4, 3 IMM.
- load_type_w  in  3  load format: 0 LB, 1 LH, 2 LW, 3 LD, 4 LBU, 5 LHU, 6 LWU.
- byte_off_w  in  OFF_W  low address bits of the load.
- write_reg_w  in  REG_AW  destination register.
- alu_out_w, read_data_w, pc_plus4_w, imm_w  in  XLEN  candidate results.
- reg_write_ds  out  1  registered write enable.
- write_reg_ds  out  REG_AW  registered destination register.
- data_out  out  XLEN  registered write data.
- valid_ds  out  1  registered valid.
- instret  out  64  retired-instruction count; present only with WB_INSTRET_EN.

## Operation
- Result mux:
  - ALU selects alu_out_w.
  - LOAD selects the extended load value.
  - PC4 selects pc_plus4_w (JAL/JALR).
  - IMM selects imm_w (LUI).
- Load extraction:
  - Byte lane = read_data_w >> (8*byte_off_w).
  - Halfword offsets ignore bit 0; word offsets ignore bits 1:0.
  - LB/LH/LW sign-extend to XLEN; LBU/LHU/LWU zero-extend.
  - LD passes all 64 bits through.
  - When XLEN=32: LD and LWU behave as LW, and the offset is 2 bits.
  - Code 7 is treated as LW.
- Effective write enable = reg_write_w & valid_w & (write_reg_w != 0). Writes to x0 are never issued.
- Output register update, in priority order:
  1. flush_w: valid_ds=0, reg_write_ds=0, write_reg_ds=0, data_out=0. Flush wins over stall.
  2. else stall_w: all outputs hold.
  3. else: capture the mux result, effective write enable, write_reg_w and valid_w.
- The output is never modified except by capture, flush or reset.

## Timing
- Latency is one cycle: inputs present before edge N appear on the outputs after edge N.
- Reset (reset=0): all outputs go to 0 immediately, without waiting for a clock edge. instret also goes to 0.
- Reset deasserted: first capture occurs on the first rising edge with reset=1.
- Reset asserted mid-stall or mid-flush: outputs clear, and the pending stall state is discarded.
- instret:
  - Increments by 1 on each edge that captures valid_w=1 (no stall, no flush), including instructions with reg_write_w=0.
  - Wraps from 2^64-1 to 0.
  - Visible one cycle after the capture, aligned with valid_ds.
- Stall held for K cycles: outputs are constant for K cycles and instret does not advance.

## Configuration
- WB_INSTRET_EN:
  - Defined: the 64-bit instret register and port exist.
  - Undefined: no counter flops and no instret port. All other behaviour is identical.

## Structure
- Shared package wb_pkg holds:
  - result_sel_e (ALU, LOAD, PC4, IMM).
  - load_type_e (LB through LWU).
  - Localparam constants for the zero register address.
- One combinational sub-module, load_extend, parametrised by XLEN. Inputs: read data, load type, offset. Output: extended value.
- The output register, valid logic and counter live in writeback_unit.

## Test plan
- Reset/x0:
  - Hold reset=0, drive alu_out_w=0xDEADBEEF, then release reset -> all outputs are 0 during reset.
  - Capture with write_reg_w=0, reg_write_w=1 -> reg_write_ds=0 on the next cycle.
- Load extend (XLEN=32), read_data_w=0x80F1_7F02:
  - LB off=3 -> 0xFFFF_FF80.
  - LBU off=3 -> 0x0000_0080.
  - LH off=2 -> 0xFFFF_80F1.
  - LHU off=0 -> 0x0000_7F02.
  - LW -> 0x80F1_7F02.
- Source select:
  - PC4 with pc_plus4_w=0x104 -> data_out=0x104 after one edge.
  - IMM with imm_w=0x12345000 -> data_out=0x12345000.
- Stall/flush:
  - Capture 0xA, then stall 3 cycles with new inputs -> data_out stays 0xA.
  - Assert stall and flush together -> bubble: valid_ds=0, reg_write_ds=0, data_out=0.
- instret (WB_INSTRET_EN):
  - 5 valid captures, 2 bubbles, 1 stalled cycle, 1 flush -> instret=5.
  - Preload 2^64-1 by force, then 1 capture -> instret=0.
- XLEN=64:
  - LWU off=4 on 0x8000_0001_0000_0000 -> 0x0000_0000_8000_0001.
  - LW at the same offset -> 0xFFFF_FFFF_8000_0001.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
// Result-source and load-format encodings match the decode stage control fields.
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_LOAD = 2'd1,
    RES_PC4  = 2'd2,
    RES_IMM  = 2'd3
  } result_sel_e;

  typedef enum logic [2:0] {
    LT_LB  = 3'd0,
    LT_LH  = 3'd1,
    LT_LW  = 3'd2,
    LT_LD  = 3'd3,
    LT_LBU = 3'd4,
    LT_LHU = 3'd5,
    LT_LWU = 3'd6
  } load_type_e;

  localparam int ZERO_REG_ADDR = 0;

endpackage

// File: rtl/load_extend.sv
// Combinational sub-word load extraction with sign/zero extension.
// Offsets are aligned down to the access size before the lane shift.
module load_extend
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  read_data,
  input  logic [2:0]       load_type,
  input  logic [OFF_W-1:0] byte_off,
  output logic [XLEN-1:0]  ext_data
);

  localparam bit IS_RV64 = (XLEN == 64);

  logic [OFF_W-1:0] half_off;
  logic [OFF_W-1:0] word_off;
  logic [7:0]       byte_val;
  logic [15:0]      half_val;
  logic [31:0]      word_val;
  logic [XLEN-1:0]  sext_b;
  logic [XLEN-1:0]  zext_b;
  logic [XLEN-1:0]  sext_h;
  logic [XLEN-1:0]  zext_h;
  logic [XLEN-1:0]  sext_w;
  logic [XLEN-1:0]  zext_w;
  logic [XLEN-1:0]  dword_val;

  assign half_off = byte_off & ~OFF_W'(1);
  assign word_off = byte_off & ~OFF_W'(3);

  assign byte_val = 8'(read_data >> {byte_off, 3'b000});
  assign half_val = 16'(read_data >> {half_off, 3'b000});
  assign word_val = 32'(read_data >> {word_off, 3'b000});

  assign sext_b = {{(XLEN-8){byte_val[7]}}, byte_val};
  assign zext_b = {{(XLEN-8){1'b0}}, byte_val};
  assign sext_h = {{(XLEN-16){half_val[15]}}, half_val};
  assign zext_h = {{(XLEN-16){1'b0}}, half_val};

  // On RV32 a word already fills the datapath, so LD and LWU collapse onto LW.
  generate
    if (IS_RV64) begin : g_rv64
      assign sext_w    = {{(XLEN-32){word_val[31]}}, word_val};
      assign zext_w    = {{(XLEN-32){1'b0}}, word_val};
      assign dword_val = read_data;
    end else begin : g_rv32
      assign sext_w    = XLEN'(word_val);
      assign zext_w    = XLEN'(word_val);
      assign dword_val = XLEN'(word_val);
    end
  endgenerate

  always_comb begin
    ext_data = sext_w;
    case (load_type)
      LT_LB:   ext_data = sext_b;
      LT_LH:   ext_data = sext_h;
      LT_LD:   ext_data = dword_val;
      LT_LBU:  ext_data = zext_b;
      LT_LHU:  ext_data = zext_h;
      LT_LWU:  ext_data = zext_w;
      default: ext_data = sext_w;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: result select, load extension and the registered write port.
// Define WB_INSTRET_EN to build in the 64-bit retired-instruction counter.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int OFF_W  = $clog2(XLEN/8)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_w,
  input  logic              stall_w,
  input  logic              flush_w,
  input  logic              reg_write_w,
  input  logic [1:0]        result_sel_w,
  input  logic [2:0]        load_type_w,
  input  logic [OFF_W-1:0]  byte_off_w,
  input  logic [REG_AW-1:0] write_reg_w,
  input  logic [XLEN-1:0]   alu_out_w,
  input  logic [XLEN-1:0]   read_data_w,
  input  logic [XLEN-1:0]   pc_plus4_w,
  input  logic [XLEN-1:0]   imm_w,
  output logic              reg_write_ds,
  output logic [REG_AW-1:0] write_reg_ds,
  output logic [XLEN-1:0]   data_out,
  output logic              valid_ds
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]       instret
`endif
);

  logic [XLEN-1:0]   load_value;
  logic [XLEN-1:0]   result_next;
  logic              write_en_next;
  logic              capture;
  logic              valid_reg;
  logic              reg_write_reg;
  logic [REG_AW-1:0] write_reg_reg;
  logic [XLEN-1:0]   data_reg;

  load_extend #(
    .XLEN (XLEN),
    .OFF_W(OFF_W)
  ) u_load_extend (
    .read_data(read_data_w),
    .load_type(load_type_w),
    .byte_off (byte_off_w),
    .ext_data (load_value)
  );

  always_comb begin
    result_next = alu_out_w;
    case (result_sel_w)
      RES_LOAD: result_next = load_value;
      RES_PC4:  result_next = pc_plus4_w;
      RES_IMM:  result_next = imm_w;
      default:  result_next = alu_out_w;
    endcase
  end

  // x0 is hardwired to zero, so a write to it is never presented to the register file.
  assign write_en_next = reg_write_w & valid_w & (write_reg_w != REG_AW'(ZERO_REG_ADDR));
  assign capture       = ~flush_w & ~stall_w;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_reg     <= 1'b0;
      reg_write_reg <= 1'b0;
      write_reg_reg <= '0;
      data_reg      <= '0;
    end else if (flush_w) begin
      valid_reg     <= 1'b0;
      reg_write_reg <= 1'b0;
      write_reg_reg <= '0;
      data_reg      <= '0;
    end else if (capture) begin
      valid_reg     <= valid_w;
      reg_write_reg <= write_en_next;
      write_reg_reg <= write_reg_w;
      data_reg      <= result_next;
    end
  end

  assign valid_ds     = valid_reg;
  assign reg_write_ds = reg_write_reg;
  assign write_reg_ds = write_reg_reg;
  assign data_out     = data_reg;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_reg;

  // Counts every captured real instruction, including ones that write no register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instret_reg <= '0;
    end else if (capture && valid_w) begin
      instret_reg <= instret_reg + 64'd1;
    end
  end

  assign instret = instret_reg;
`else
  // Counter not built: no extra state beyond the output register.
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: RV32 and RV64 instances share control stimulus.
// A byte-level reference model predicts the registered outputs every cycle.
module tb_writeback_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid_w, stall_w, flush_w, reg_write_w;
  logic [1:0]  result_sel_w;
  logic [2:0]  load_type_w;
  logic [2:0]  byte_off_w;
  logic [4:0]  write_reg_w;
  logic [63:0] alu64, rd64, pc64, imm64;

  logic        rw32, v32, rw64, v64;
  logic [4:0]  wr32, wr64;
  logic [31:0] d32;
  logic [63:0] d64;
`ifdef WB_INSTRET_EN
  logic [63:0] ir32, ir64;
`endif

  // Reference model state
  logic        m_v, m_we;
  logic [4:0]  m_wr;
  logic [31:0] m_d32;
  logic [63:0] m_d64;
  logic [63:0] m_ir;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  writeback_unit #(.XLEN(32), .REG_AW(5)) dut32 (
    .clock       (clock),
    .reset       (reset),
    .valid_w     (valid_w),
    .stall_w     (stall_w),
    .flush_w     (flush_w),
    .reg_write_w (reg_write_w),
    .result_sel_w(result_sel_w),
    .load_type_w (load_type_w),
    .byte_off_w  (byte_off_w[1:0]),
    .write_reg_w (write_reg_w),
    .alu_out_w   (alu64[31:0]),
    .read_data_w (rd64[31:0]),
    .pc_plus4_w  (pc64[31:0]),
    .imm_w       (imm64[31:0]),
    .reg_write_ds(rw32),
    .write_reg_ds(wr32),
    .data_out    (d32),
    .valid_ds    (v32)
`ifdef WB_INSTRET_EN
    ,
    .instret     (ir32)
`endif
  );

  writeback_unit #(.XLEN(64), .REG_AW(5)) dut64 (
    .clock       (clock),
    .reset       (reset),
    .valid_w     (valid_w),
    .stall_w     (stall_w),
    .flush_w     (flush_w),
    .reg_write_w (reg_write_w),
    .result_sel_w(result_sel_w),
    .load_type_w (load_type_w),
    .byte_off_w  (byte_off_w),
    .write_reg_w (write_reg_w),
    .alu_out_w   (alu64),
    .read_data_w (rd64),
    .pc_plus4_w  (pc64),
    .imm_w       (imm64),
    .reg_write_ds(rw64),
    .write_reg_ds(wr64),
    .data_out    (d64),
    .valid_ds    (v64)
`ifdef WB_INSTRET_EN
    ,
    .instret     (ir64)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Load value from the ISA definition: access size, alignment, then extension.
  function automatic logic [63:0] model_load(input logic [63:0] rd, input int xlen,
                                             input int lt, input int off);
    int size;
    bit sgn;
    int base;
    logic [63:0] v;
    logic [63:0] mask;
    size = 4;
    sgn  = 1'b1;
    case (lt)
      0: begin size = 1; sgn = 1'b1; end
      1: begin size = 2; sgn = 1'b1; end
      3: if (xlen == 64) size = 8;
      4: begin size = 1; sgn = 1'b0; end
      5: begin size = 2; sgn = 1'b0; end
      6: sgn = (xlen != 64);
      default: ;
    endcase
    base = off - (off % size);
    v = rd >> (8 * base);
    if (size < 8) begin
      mask = (64'd1 << (8 * size)) - 64'd1;
      v = v & mask;
      if (sgn && v[8*size-1]) v = v | ~mask;
    end
    if (xlen == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  function automatic logic [63:0] model_result(input int xlen);
    logic [63:0] msk;
    msk = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case (result_sel_w)
      2'd0:    return alu64 & msk;
      2'd1:    return model_load(rd64 & msk, xlen, int'(load_type_w),
                                 (xlen == 64) ? int'(byte_off_w) : int'(byte_off_w[1:0]));
      2'd2:    return pc64 & msk;
      default: return imm64 & msk;
    endcase
  endfunction

  task automatic model_bubble();
    m_v   = 1'b0;
    m_we  = 1'b0;
    m_wr  = '0;
    m_d32 = '0;
    m_d64 = '0;
  endtask

  task automatic model_clear();
    model_bubble();
    m_ir = '0;
  endtask

  // Outputs expected after the coming edge, given the inputs applied now.
  task automatic model_step();
    logic [63:0] r;
    if (!reset) begin
      model_clear();
    end else if (flush_w) begin
      model_bubble();
    end else if (!stall_w) begin
      m_v   = valid_w;
      m_we  = reg_write_w && valid_w && (write_reg_w != 5'd0);
      m_wr  = write_reg_w;
      r     = model_result(32);
      m_d32 = r[31:0];
      m_d64 = model_result(64);
      if (valid_w) m_ir = m_ir + 64'd1;
    end
  endtask

  task automatic check_all();
    chk("valid32", {63'd0, v32}, {63'd0, m_v});
    chk("we32", {63'd0, rw32}, {63'd0, m_we});
    chk("wr32", {59'd0, wr32}, {59'd0, m_wr});
    chk("data32", {32'd0, d32}, {32'd0, m_d32});
    chk("valid64", {63'd0, v64}, {63'd0, m_v});
    chk("we64", {63'd0, rw64}, {63'd0, m_we});
    chk("wr64", {59'd0, wr64}, {59'd0, m_wr});
    chk("data64", d64, m_d64);
`ifdef WB_INSTRET_EN
    chk("instret32", ir32, m_ir);
    chk("instret64", ir64, m_ir);
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    model_clear();
    check_all();
  endtask

  task automatic drive(input logic v, input logic s, input logic f, input logic rw,
                       input logic [1:0] sel, input logic [2:0] lt, input logic [2:0] off,
                       input logic [4:0] wr);
    valid_w      = v;
    stall_w      = s;
    flush_w      = f;
    reg_write_w  = rw;
    result_sel_w = sel;
    load_type_w  = lt;
    byte_off_w   = off;
    write_reg_w  = wr;
  endtask

  task automatic randomize_inputs();
    valid_w      = ($urandom_range(0, 9) < 8);
    stall_w      = ($urandom_range(0, 9) < 2);
    flush_w      = ($urandom_range(0, 9) == 0);
    reg_write_w  = ($urandom_range(0, 3) != 0);
    result_sel_w = 2'($urandom_range(0, 3));
    load_type_w  = 3'($urandom_range(0, 7));
    byte_off_w   = 3'($urandom_range(0, 7));
    write_reg_w  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    alu64        = {$urandom(), $urandom()};
    rd64         = {$urandom(), $urandom()};
    pc64         = {$urandom(), $urandom()};
    imm64        = {$urandom(), $urandom()};
  endtask

  logic [2:0]  lt_tab  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [2:0]  off_tab [5] = '{3'd3, 3'd3, 3'd2, 3'd0, 3'd0};
  logic [31:0] exp_tab [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80F1,
                               32'h0000_7F02, 32'h80F1_7F02};

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd2, 3'd0, 5'd5);
    alu64 = 64'h0000_0000_DEAD_BEEF;
    rd64  = '0;
    pc64  = '0;
    imm64 = '0;
    model_clear();

    // Reset held low: outputs clear without a clock edge and stay clear.
    async_reset();
    chk("reset_data", {32'd0, d32}, 64'd0);
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    chk("first_capture", {32'd0, d32}, 64'h0000_0000_DEAD_BEEF);

    // Write to x0 is suppressed.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd2, 3'd0, 5'd0);
    cycle();
    chk("x0_we", {63'd0, rw32}, 64'd0);

    // Sub-word loads on RV32.
    rd64 = 64'h0000_0000_80F1_7F02;
    for (int i = 0; i < 5; i++) begin
      chk("pin_model_load", model_load(rd64, 32, int'(lt_tab[i]), int'(off_tab[i])),
          {32'd0, exp_tab[i]});
      drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, lt_tab[i], off_tab[i], 5'd7);
      cycle();
      chk("load32", {32'd0, d32}, {32'd0, exp_tab[i]});
    end

    // Source select.
    pc64 = 64'h104;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 3'd0, 3'd0, 5'd1);
    cycle();
    chk("pc4", {32'd0, d32}, 64'h104);
    imm64 = 64'h1234_5000;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 3'd0, 3'd0, 5'd2);
    cycle();
    chk("imm", {32'd0, d32}, 64'h1234_5000);

    // Stall holds the output while inputs keep changing.
    alu64 = 64'hA;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 3'd0, 5'd3);
    cycle();
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      stall_w = 1'b1;
      flush_w = 1'b0;
      cycle();
      chk("stall_hold", {32'd0, d32}, 64'hA);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 3'd0, 3'd0, 5'd3);
    cycle();
    chk("flush_valid", {63'd0, v32}, 64'd0);
    chk("flush_we", {63'd0, rw32}, 64'd0);
    chk("flush_data", {32'd0, d32}, 64'd0);

    // RV64 word loads at the upper word.
    rd64 = 64'h8000_0001_0000_0000;
    chk("pin_lwu64", model_load(rd64, 64, 6, 4), 64'h0000_0000_8000_0001);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 3'd6, 3'd4, 5'd9);
    cycle();
    chk("lwu64", d64, 64'h0000_0000_8000_0001);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 3'd2, 3'd4, 5'd9);
    cycle();
    chk("lw64", d64, 64'hFFFF_FFFF_8000_0001);

`ifdef WB_INSTRET_EN
    async_reset();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 5'd4);
      cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 3'd0, 5'd4);
    cycle();
    cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 3'd0, 5'd4);
    cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 3'd0, 5'd4);
    cycle();
    chk("instret_count", ir32, 64'd5);
    force dut32.instret_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    force dut64.instret_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut32.instret_reg;
    release dut64.instret_reg;
    m_ir = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 3'd0, 5'd4);
    cycle();
    chk("instret_wrap", ir32, 64'd0);
`endif

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      if ($urandom_range(0, 39) == 0) async_reset();
      else reset = 1'b1;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
